// File: rtl/parity_rx.sv
// Serial 9-bit frame receiver: 8 data bits LSB first plus a parity bit.
// Presents the byte with a parity-error flag and keeps a saturating error count.
module parity_rx #(
  parameter bit          ODD_PARITY = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  input  logic             err_clr,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_abort,
  output logic             busy,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             parity_err_q, parity_err_d;
  logic             frame_abort_q, frame_abort_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             check;

  assign check = (^shift_q) ^ bit_in ^ ODD_PARITY;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    parity_err_d  = parity_err_q;
    err_count_d   = err_count_q;
    data_valid_d  = 1'b0;
    frame_abort_d = 1'b0;

    if (bit_valid) begin
      if (sof) begin
        // A sof always starts a fresh frame; any partial frame is thrown away.
        frame_abort_d = (state_q != StIdle);
        shift_d       = {7'b0, bit_in};
        bit_cnt_d     = 3'd1;
        state_d       = StData;
      end else begin
        unique case (state_q)
          StIdle: ;
          StData: begin
            shift_d[bit_cnt_q] = bit_in;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = StParity;
            end
          end
          StParity: begin
            data_out_d   = shift_q;
            parity_err_d = check;
            data_valid_d = 1'b1;
            bit_cnt_d    = 3'd0;
            state_d      = StIdle;
            if (check && (err_count_q != CntMax)) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    if (err_clr) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      data_out_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      frame_abort_q <= frame_abort_d;
      err_count_q   <= err_count_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_abort = frame_abort_q;
  assign busy        = (state_q != StIdle);
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: one even-parity/8-bit-counter instance and one
// odd-parity/2-bit-counter instance, each driven by its own stimulus lines.
module tb_parity_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] bi  = '0;
  logic [1:0] bv  = '0;
  logic [1:0] sf  = '0;
  logic [1:0] clr = '0;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1, perr0, perr1, fa0, fa1, busy0, busy1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  int  dv_seen0 = 0, dv_seen1 = 0, fa_seen0 = 0, busy_drop0 = 0;
  bit  mon_busy0 = 1'b0;

  always #5 clk = ~clk;

  parity_rx #(.ODD_PARITY(1'b0), .CNT_W(8)) u_even (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bi[0]),
    .bit_valid  (bv[0]),
    .sof        (sf[0]),
    .err_clr    (clr[0]),
    .data_out   (dout0),
    .data_valid (dv0),
    .parity_err (perr0),
    .frame_abort(fa0),
    .busy       (busy0),
    .err_count  (cnt0)
  );

  parity_rx #(.ODD_PARITY(1'b1), .CNT_W(2)) u_odd (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bi[1]),
    .bit_valid  (bv[1]),
    .sof        (sf[1]),
    .err_clr    (clr[1]),
    .data_out   (dout1),
    .data_valid (dv1),
    .parity_err (perr1),
    .frame_abort(fa1),
    .busy       (busy1),
    .err_count  (cnt1)
  );

  // Pulse counters sample the value registered on the previous edge.
  always @(posedge clk) begin
    if (dv0) dv_seen0++;
    if (dv1) dv_seen1++;
    if (fa0) fa_seen0++;
    if (mon_busy0 && !busy0) busy_drop0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one bit across the next rising edge.
  task automatic send_bit(input int d, input logic b, input logic s, input logic c);
    bi[d]  = b;
    sf[d]  = s;
    bv[d]  = 1'b1;
    clr[d] = c;
    @(posedge clk);
    @(negedge clk);
    bv[d]  = 1'b0;
    sf[d]  = 1'b0;
    clr[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic frame(input int d, input logic [7:0] b, input logic p, input bit gaps,
                       input bit clr_par);
    for (int i = 0; i < 8; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      send_bit(d, b[i], (i == 0), 1'b0);
    end
    if (gaps) idle($urandom_range(0, 3));
    send_bit(d, p, 1'b0, clr_par);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_dout0", dout0, 8'h00);
    chk("rst_dv0", dv0, 1'b0);
    chk("rst_perr0", perr0, 1'b0);
    chk("rst_fa0", fa0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_cnt0", cnt0, 8'h00);
    chk("rst_cnt1", cnt1, 2'd0);
    rst = 1'b0;
    @(negedge clk);

    // Even parity, 0xA5 correct
    frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_dv", dv0, 1'b1);
    chk("a5_dout", dout0, 8'hA5);
    chk("a5_perr", perr0, 1'b0);
    chk("a5_cnt", cnt0, 8'd0);
    chk("a5_busy", busy0, 1'b0);
    idle(1);
    chk("a5_dv_1cyc", dv0, 1'b0);
    chk("a5_dout_held", dout0, 8'hA5);

    // Even parity, 0xA5 bad then 0x07 good
    frame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a5bad_perr", perr0, 1'b1);
    chk("a5bad_cnt", cnt0, 8'd1);
    frame(0, 8'h07, 1'b1, 1'b0, 1'b0);
    chk("07_dout", dout0, 8'h07);
    chk("07_perr", perr0, 1'b0);
    chk("07_cnt", cnt0, 8'd1);
    idle(1);

    // Abort after 4 bits of 0xFF, then gapped 0x3C frame
    dv_seen0 = 0;
    fa_seen0 = 0;
    busy_drop0 = 0;
    send_bit(0, 1'b1, 1'b1, 1'b0);
    mon_busy0 = 1'b1;
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0, 1'b0);
    idle(2);
    send_bit(0, 1'b0, 1'b1, 1'b0);
    chk("abort_fa", fa0, 1'b1);
    chk("abort_dout_held", dout0, 8'h07);
    for (int i = 1; i < 8; i++) begin
      idle($urandom_range(0, 3));
      send_bit(0, 8'h3C >> i, 1'b0, 1'b0);
    end
    idle(2);
    send_bit(0, 1'b0, 1'b0, 1'b0);
    mon_busy0 = 1'b0;
    chk("abort_dv", dv0, 1'b1);
    chk("abort_dout", dout0, 8'h3C);
    chk("abort_perr", perr0, 1'b0);
    idle(2);
    chk("abort_fa_count", fa_seen0, 1);
    chk("abort_dv_count", dv_seen0, 1);
    chk("abort_busy_drops", busy_drop0, 0);
    chk("abort_cnt", cnt0, 8'd1);

    // Odd parity instance
    frame(1, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("odd01_dout", dout1, 8'h01);
    chk("odd01_perr", perr1, 1'b0);
    chk("odd01_cnt", cnt1, 2'd0);
    frame(1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("odd00_perr", perr1, 1'b1);
    chk("odd00_cnt", cnt1, 2'd1);

    // Saturation of the 2-bit counter (5 bad frames in total), with gaps
    frame(1, 8'h00, 1'b0, 1'b1, 1'b0);
    frame(1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt3", cnt1, 2'd3);
    frame(1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("sat_hold4", cnt1, 2'd3);
    frame(1, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("sat_hold5", cnt1, 2'd3);
    frame(1, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_prio_cnt", cnt1, 2'd0);
    chk("clr_prio_perr", perr1, 1'b1);
    idle(1);

    // Reset mid-frame
    dv_seen0 = 0;
    send_bit(0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_busy", busy0, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy0, 1'b0);
    chk("rst_mid_dv", dv0, 1'b0);
    chk("rst_mid_cnt", cnt0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("rst_mid_no_dv", dv_seen0, 0);

    // Back-to-back frames, no gaps
    frame(0, 8'h12, 1'b0, 1'b0, 1'b0);
    chk("b2b1_dv", dv0, 1'b1);
    chk("b2b1_dout", dout0, 8'h12);
    chk("b2b1_perr", perr0, 1'b0);
    send_bit(0, 1'b0, 1'b1, 1'b0);
    chk("b2b2_start_dv", dv0, 1'b0);
    chk("b2b2_no_abort", fa0, 1'b0);
    for (int i = 1; i < 8; i++) send_bit(0, 8'h34 >> i, 1'b0, 1'b0);
    chk("b2b2_pre_par_dv", dv0, 1'b0);
    send_bit(0, 1'b1, 1'b0, 1'b0);
    chk("b2b2_dv", dv0, 1'b1);
    chk("b2b2_dout", dout0, 8'h34);
    chk("b2b2_perr", perr0, 1'b0);
    idle(2);
    chk("b2b_dv_count", dv_seen0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_rx.md
# parity_rx

Serial receive-side companion to the team's 8-bit parity generator. It deserialises 9-bit frames (8 data bits LSB first, then the parity bit the generator appended), checks parity, and presents the byte with an error flag. It also keeps a saturating parity-error count. It sits between a serial link front end and the byte-wide consumer logic.

## Interface
- ODD_PARITY, 0, 0 = even parity (XOR of all 9 frame bits must be 0); 1 = odd parity (XOR must be 1)
- CNT_W, 8, width of the error counter (≥2)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous and active-high
- bit_in  in  1  serial frame bit, sampled only when bit_valid=1
- bit_valid  in  1  qualifies bit_in; low cycles are gaps and are ignored
- sof  in  1  start of frame; meaningful only with bit_valid=1; marks bit_in as data bit 0
- err_clr  in  1  synchronous clear of err_count
- data_out  out  8  last received byte, held until next completed frame
- data_valid  out  1  one-cycle pulse: frame complete, data_out/parity_err updated
- parity_err  out  1  parity check result of last completed frame, held
- frame_abort  out  1  one-cycle pulse: frame in progress abandoned by new sof
- busy  out  1  high while a frame is in progress (state ≠ IDLE)
- err_count  out  CNT_W  number of frames with a parity error, saturating

## Operation
- States: IDLE, DATA, PARITY.
- IDLE: a bit is accepted only if bit_valid=1 and sof=1. That bit is stored as data bit 0, bit_cnt=1, and the state moves to DATA. bit_valid=1 with sof=0 is ignored.
- DATA: each bit_valid=1 cycle (sof=0) stores bit_in at position bit_cnt and increments bit_cnt. The bit that fills position 7 moves the state to PARITY.
- PARITY: the next bit_valid=1 (sof=0) is the parity bit.
  - check = XOR(data[7:0], bit_in) XOR ODD_PARITY.
  - parity_err <= check, data_out <= data, data_valid pulses.
  - State returns to IDLE.
- The received parity bit is never stored in data_out.
- sof=1 with bit_valid=1 in DATA or PARITY:
  - frame_abort pulses for 1 cycle.
  - The partial frame is discarded; data_out and parity_err are unchanged and no data_valid is produced.
  - The sof bit becomes data bit 0 of a new frame, with bit_cnt=1 and state DATA.
- err_count increments by 1 on each data_valid with check=1 and saturates at 2^CNT_W−1.
- err_clr=1 forces err_count to 0 and takes priority over a same-cycle increment.
- busy = (state ≠ IDLE).

## Timing
- Reset values: data_out=0x00, data_valid=0, parity_err=0, frame_abort=0, busy=0, err_count=0, state=IDLE, bit_cnt=0.
- Reset asserted mid-frame drops the partial frame immediately; no pulses are generated.
- Latency: data_out, parity_err, data_valid and err_count all update on the rising edge that samples the parity bit. They are visible in the following cycle.
- data_valid and frame_abort are exactly 1 cycle wide.
- With no gaps, a frame takes 9 consecutive bit_valid cycles.
- The cycle after the parity bit, the block is in IDLE and accepts a new sof, so back-to-back frames run with zero dead cycles.
- Gaps (bit_valid=0) of any length are allowed anywhere in a frame; state and bit_cnt hold.
- No backpressure: the consumer must capture data_out on data_valid. The next frame overwrites it.

## Test plan
- Even parity (ODD_PARITY=0): sof+bits of 0xA5 LSB first, then parity bit 0 → data_valid one cycle after the 9th bit edge, data_out=0xA5, parity_err=0, err_count=0.
- Even parity: 0xA5 with parity bit 1 → parity_err=1, err_count=1. Then 0x07 with parity bit 1 → parity_err=0, err_count stays 1.
- ODD_PARITY=1: 0x01 with parity bit 0 → parity_err=0. 0x00 with parity bit 0 → parity_err=1.
- Abort and gaps: sof + 4 bits of 0xFF, then sof + 0x3C + correct parity with random bit_valid gaps →
  - frame_abort pulses once at the second sof;
  - exactly one data_valid follows, with data_out=0x3C and parity_err=0;
  - busy stays high throughout.
- Saturation and clear, CNT_W=2: 5 bad frames → err_count reaches 3 and stays 3. Then err_clr in the same cycle as a 6th bad frame's parity bit → err_count=0.
- Reset and back-to-back:
  - rst asserted after 6 bits → busy=0 at once, no data_valid.
  - Then two back-to-back frames (0x12 and 0x34, correct parity, no gaps) → data_valid pulses at cycles 9 and 18 with data_out 0x12 and 0x34.
